// File: rtl/comm_io_decoder.sv
// Comm-region I/O decoder: turns CPU strobes into per-channel ACIA port/baud selects,
// inserts wait states before DTACK_L, and faults unmapped comm-region accesses.
module comm_io_decoder #(
    parameter int NUM_CH      = 2,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       Address,
    input  logic              IOSelect,
    input  logic              AS_L,
    output logic [NUM_CH-1:0] ACIA_Port_Enable,
    output logic [NUM_CH-1:0] ACIA_Baud_Enable,
    output logic              DTACK_L,
    output logic              Bus_Error,
    output logic [1:0]        fsm_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]        state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [2:0]        ch_q, ch_nx;
    logic              baud_q, baud_nx;
    logic              armed, armed_nx;
    logic [NUM_CH-1:0] sel;

    logic [2:0] addr_ch;
    logic [3:0] offset;
    logic       hit;
    logic       ch_ok;
    logic       is_port;
    logic       is_baud;
    logic       mapped;
    logic       unused_addr;

    assign addr_ch     = Address[6:4];
    assign offset      = Address[3:0];
    assign unused_addr = ^{Address[31:16], Address[14:7]};

    // Bus handshake: the CPU requests with AS_L low; the decoder answers with DTACK_L low
    // (or Bus_Error high) and holds it until AS_L rises, and AS_L rising always ends the access.
    // armed blocks a strobe that was already low when reset released from being taken as new.
    assign hit     = IOSelect && Address[15] && !AS_L && armed;
    assign ch_ok   = ({1'b0, addr_ch} < 4'(NUM_CH));
    assign is_port = (offset == 4'h0) || (offset == 4'h4);
    assign is_baud = (offset == 4'h8);
    assign mapped  = ch_ok && (is_port || is_baud);

    assign fsm_state = state;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ch_nx    = ch_q;
        baud_nx  = baud_q;
        armed_nx = armed | AS_L;
        case (state)
            S_IDLE: begin
                if (hit) begin
                    if (mapped) begin
                        ch_nx    = addr_ch;
                        baud_nx  = is_baud;
                        cnt_nx   = 4'd0;
                        state_nx = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                    end else begin
                        state_nx = S_ERR;
                    end
                end
            end
            S_WAIT: begin
                cnt_nx = cnt + 4'd1;
                if (AS_L) begin
                    state_nx = S_IDLE;
                end else if (cnt == WAIT_LAST) begin
                    state_nx = S_ACK;
                end
            end
            S_ACK, S_ERR: begin
                if (AS_L) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i] = (ch_q == 3'(i));
        end
    end

    // Outputs are registered from the state held during the cycle, so they trail it by one edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            cnt              <= 4'd0;
            ch_q             <= 3'd0;
            baud_q           <= 1'b0;
            armed            <= 1'b0;
            ACIA_Port_Enable <= '0;
            ACIA_Baud_Enable <= '0;
            DTACK_L          <= 1'b1;
            Bus_Error        <= 1'b0;
        end else begin
            state            <= state_nx;
            cnt              <= cnt_nx;
            ch_q             <= ch_nx;
            baud_q           <= baud_nx;
            armed            <= armed_nx;
            ACIA_Port_Enable <= ((state == S_WAIT || state == S_ACK) && !baud_q) ? sel : '0;
            ACIA_Baud_Enable <= ((state == S_WAIT || state == S_ACK) && baud_q) ? sel : '0;
            DTACK_L          <= (state != S_ACK);
            Bus_Error        <= (state == S_ERR);
        end
    end

endmodule

// File: tb/tb_comm_io_decoder.sv
// Bench for comm_io_decoder: two instances (2 and 0 wait states) share stimulus and are
// compared every cycle against an access-age model, plus hand-computed directed checks.
module tb_comm_io_decoder;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] Address;
    logic        IOSelect;
    logic        AS_L;

    logic [NCH-1:0] pe_a, be_a, pe_b, be_b;
    logic           dt_a, err_a, dt_b, err_b;
    logic [1:0]     st_a, st_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    comm_io_decoder #(.NUM_CH(NCH), .WAIT_CYCLES(2)) dut_w2 (
        .clk              (clk),
        .reset_n          (reset_n),
        .Address          (Address),
        .IOSelect         (IOSelect),
        .AS_L             (AS_L),
        .ACIA_Port_Enable (pe_a),
        .ACIA_Baud_Enable (be_a),
        .DTACK_L          (dt_a),
        .Bus_Error        (err_a),
        .fsm_state        (st_a)
    );

    comm_io_decoder #(.NUM_CH(NCH), .WAIT_CYCLES(0)) dut_w0 (
        .clk              (clk),
        .reset_n          (reset_n),
        .Address          (Address),
        .IOSelect         (IOSelect),
        .AS_L             (AS_L),
        .ACIA_Port_Enable (pe_b),
        .ACIA_Baud_Enable (be_b),
        .DTACK_L          (dt_b),
        .Bus_Error        (err_b),
        .fsm_state        (st_b)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // An access is either absent or "in flight" with an age in cycles; the outputs seen after
    // an edge describe the access as it stood during the cycle before that edge.
    typedef struct packed {
        bit             busy;
        logic [7:0]     age;
        logic [2:0]     ch;
        logic [1:0]     kind;   // 0 port, 1 baud, 2 fault
        logic [NCH-1:0] pe;
        logic [NCH-1:0] be;
        logic           dt;
        logic           err;
    } mstate_t;

    mstate_t m_w2 = '0;
    mstate_t m_w0 = '0;
    bit      m_armed = 1'b0;

    function automatic mstate_t step(mstate_t s, int wc, logic rst_n, bit armd,
                                     logic ios, logic as_l, logic [31:0] a);
        mstate_t n;
        logic [3:0] off;
        n     = s;
        n.pe  = '0;
        n.be  = '0;
        n.dt  = 1'b1;
        n.err = 1'b0;
        off   = a[3:0];
        if (!rst_n) begin
            n.busy = 1'b0;
            n.age  = '0;
            return n;
        end
        if (s.busy) begin
            if (s.kind == 2'd2) begin
                n.err = 1'b1;
            end else begin
                if (s.kind == 2'd1) n.be[s.ch] = 1'b1;
                else                n.pe[s.ch] = 1'b1;
                n.dt = !(int'(s.age) >= wc);
            end
            if (s.age != 8'hFF) n.age = s.age + 8'd1;
            if (as_l) n.busy = 1'b0;
        end else if (armd && ios && a[15] && !as_l) begin
            n.busy = 1'b1;
            n.age  = '0;
            n.ch   = a[6:4];
            if (int'(a[6:4]) >= NCH)           n.kind = 2'd2;
            else if (off == 4'h0 || off == 4'h4) n.kind = 2'd0;
            else if (off == 4'h8)              n.kind = 2'd1;
            else                               n.kind = 2'd2;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m_w2    <= step(m_w2, 2, reset_n, m_armed, IOSelect, AS_L, Address);
        m_w0    <= step(m_w0, 0, reset_n, m_armed, IOSelect, AS_L, Address);
        m_armed <= reset_n ? (m_armed | AS_L) : 1'b0;
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("cycle_w2", 32'({pe_a, be_a, dt_a, err_a}), 32'({m_w2.pe, m_w2.be, m_w2.dt, m_w2.err}));
            check("cycle_w0", 32'({pe_b, be_b, dt_b, err_b}), 32'({m_w0.pe, m_w0.be, m_w0.dt, m_w0.err}));
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_access(input logic [31:0] a);
        Address  = a;
        IOSelect = 1'b1;
        AS_L     = 1'b0;
    endtask

    localparam logic [9:0] IDLE_OUT = 10'b0000_0000_10;

    initial begin
        logic [31:0] a;
        int          hold;
        reset_n  = 1'b0;
        AS_L     = 1'b1;
        IOSelect = 1'b0;
        Address  = '0;
        tick();
        checking = 1'b1;
        tick(2);
        check("reset_dtack", 32'(dt_a), 32'd1);
        check("reset_outs", 32'({pe_a, be_a, err_a, pe_b, be_b, err_b}), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Port access on channel 1, address moved mid-access
        begin_access(32'h0000_8010);
        tick();
        check("port_e0_quiet", 32'({pe_a, be_a, dt_a, err_a}), 32'(IDLE_OUT));
        tick();
        check("port_en_e1", 32'(pe_a), 32'b0010);
        check("port_dt_e1", 32'(dt_a), 32'd1);
        check("w0_dt_e1", 32'(dt_b), 32'd0);
        Address = 32'h0000_8020;
        tick();
        check("port_dt_e2", 32'(dt_a), 32'd1);
        tick();
        check("port_dt_e3", 32'(dt_a), 32'd0);
        check("port_en_latched", 32'(pe_a), 32'b0010);
        AS_L = 1'b1;
        tick(2);
        check("port_release", 32'({pe_a, be_a, dt_a, err_a}), 32'(IDLE_OUT));
        tick();

        // Baud access on channel 3
        begin_access(32'h0000_8038);
        tick(2);
        check("baud_en_e1", 32'(be_a), 32'b1000);
        check("baud_port_off", 32'(pe_a), 32'd0);
        tick(2);
        check("baud_dt_e3", 32'(dt_a), 32'd0);
        AS_L = 1'b1;
        tick(3);

        // Unmapped offset
        begin_access(32'h0000_800C);
        tick(2);
        check("hole_err_e1", 32'(err_a), 32'd1);
        check("hole_no_en", 32'({pe_a, be_a}), 32'd0);
        tick(2);
        check("hole_dt_high", 32'(dt_a), 32'd1);
        AS_L = 1'b1;
        tick(2);
        check("hole_err_clear", 32'(err_a), 32'd0);
        tick();

        // Channel beyond NUM_CH, address moved to a mapped one mid-fault
        begin_access(32'h0000_8050);
        tick(2);
        check("badch_err_e1", 32'(err_a), 32'd1);
        Address = 32'h0000_8010;
        tick(2);
        check("badch_err_held", 32'({pe_a, be_a, dt_a, err_a}), 32'b0000_0000_11);
        AS_L = 1'b1;
        tick(3);

        // Non-hits: outside comm region, then IOSelect low
        begin_access(32'h0000_0010);
        tick(4);
        check("nohit_addr15", 32'({pe_a, be_a, dt_a, err_a}), 32'(IDLE_OUT));
        IOSelect = 1'b0;
        Address  = 32'h0000_8010;
        tick(4);
        check("nohit_iosel", 32'({pe_b, be_b, dt_b, err_b}), 32'(IDLE_OUT));
        AS_L = 1'b1;
        tick(2);

        // Abort during wait states
        begin_access(32'h0000_8020);
        tick(2);
        check("abort_en_e1", 32'(pe_a), 32'b0100);
        AS_L = 1'b1;
        tick();
        check("abort_dt_e2", 32'(dt_a), 32'd1);
        tick();
        check("abort_en_e3", 32'(pe_a), 32'd0);
        check("abort_dt_e3", 32'(dt_a), 32'd1);
        check("abort_w0_done", 32'(dt_b), 32'd1);
        tick(2);

        // Reset while acknowledging, strobe still low after release
        begin_access(32'h0000_8010);
        tick(4);
        check("rst_pre_dt", 32'(dt_a), 32'd0);
        reset_n = 1'b0;
        tick();
        check("rst_dt", 32'(dt_a), 32'd1);
        check("rst_en", 32'(pe_a), 32'd0);
        reset_n = 1'b1;
        tick(3);
        check("rst_stale_strobe", 32'({pe_a, be_a, dt_a, err_a}), 32'(IDLE_OUT));
        AS_L = 1'b1;
        tick();
        AS_L = 1'b0;
        tick(2);
        check("rst_fresh_hit", 32'(pe_a), 32'b0010);
        AS_L = 1'b1;
        tick(2);

        // Randomized accesses, with address churn and occasional reset
        for (int i = 0; i < 300; i++) begin
            a = $urandom();
            a[15] = ($urandom_range(0, 7) != 0);
            a[6:4] = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       a[3:0] = 4'h0;
                1:       a[3:0] = 4'h4;
                2:       a[3:0] = 4'h8;
                default: a[3:0] = 4'($urandom_range(0, 15));
            endcase
            Address  = a;
            IOSelect = ($urandom_range(0, 7) != 0);
            AS_L     = 1'b0;
            hold     = $urandom_range(1, 7);
            for (int k = 0; k < hold; k++) begin
                tick();
                if ($urandom_range(0, 3) == 0) Address = $urandom();
                reset_n = ($urandom_range(0, 60) != 0);
            end
            reset_n = 1'b1;
            AS_L    = 1'b1;
            tick($urandom_range(1, 3));
        end

        tick(2);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
